// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the control-path interlock logic.
//   - Tuse/Tnew field width and the Tuse code meaning "source not read"
//   - default multiply/divide busy latencies
//   - forward-select encoding: 0 = GRF, k+1 = scoreboard entry k
package ctrl_pkg;

    localparam int CTRL_TNEW_W = 2;

    // An all-ones Tuse marks a source operand the instruction never reads.
    localparam logic [CTRL_TNEW_W-1:0] CTRL_TUSE_UNUSED = '1;

    localparam int CTRL_MULT_CYCLES = 5;
    localparam int CTRL_DIV_CYCLES  = 10;

    // Forward-select encoding shared by the interlock and the datapath muxes.
    localparam int FWD_SEL_GRF = 0;

    function automatic int fwd_sel_entry(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/hz_src_check.sv
// hz_src_check: youngest-match search for one D-stage source register.
// Scans the scoreboard; the lowest-index valid entry writing `src` decides
// whether this source must stall and which forwarding path it may use.
// Ports:
//   sb_v, sb_a3, sb_tnew : scoreboard entries (index 0 = E stage)
//   src                  : source register read in D
//   tuse                 : cycles until the source is consumed (all-ones = unused)
//   src_stall            : producer's result will not be ready in time
//   fwd_sel              : 0 = GRF, k+1 = result of entry k
module hz_src_check
    import ctrl_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int REG_W  = 5,
    parameter int TNEW_W = CTRL_TNEW_W,
    parameter int SEL_W  = $clog2(STAGES + 1)
) (
    input  logic [STAGES-1:0]             sb_v,
    input  logic [STAGES-1:0][REG_W-1:0]  sb_a3,
    input  logic [STAGES-1:0][TNEW_W-1:0] sb_tnew,
    input  logic [REG_W-1:0]              src,
    input  logic [TNEW_W-1:0]             tuse,
    output logic                          src_stall,
    output logic [SEL_W-1:0]              fwd_sel
);

    localparam logic [TNEW_W-1:0] TUSE_UNUSED = '1;

    logic              hit;
    logic [TNEW_W-1:0] hit_tnew;
    logic [SEL_W-1:0]  hit_sel;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit      = 1'b0;
        hit_tnew = '0;
        hit_sel  = SEL_W'(FWD_SEL_GRF);
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (sb_v[k] && (sb_a3[k] == src) && (src != '0)) begin
                hit      = 1'b1;
                hit_tnew = sb_tnew[k];
                hit_sel  = SEL_W'(fwd_sel_entry(k));
            end
        end
    end

    always_comb begin
        src_stall = hit && (tuse != TUSE_UNUSED) && (hit_tnew > tuse);
        fwd_sel   = (hit && (hit_tnew == '0)) ? hit_sel : SEL_W'(FWD_SEL_GRF);
    end

endmodule

// File: rtl/ctrl_hazard_scoreboard.sv
// ctrl_hazard_scoreboard: D-stage interlock unit.
// Tracks destination register and remaining Tnew of every in-flight
// GRF-writing instruction past D, and produces the D-stage stall, the D-stage
// forwarding selects and the multiply/divide busy interlock.
// Ports:
//   clk, reset_n             : clock, asynchronous active-low reset
//   d_valid                  : D holds a real instruction
//   d_rs, d_rt               : source registers read in D
//   d_tuse_rs, d_tuse_rt     : Tuse per source (all-ones = unused)
//   d_grfwe, d_a3, d_tnew    : destination write enable, register, Tnew in E
//   d_md_start, d_md_is_div  : mult/div start and its kind
//   d_md_use                 : any HI/LO instruction
//   stall                    : hold PC and F/D, bubble into E
//   fwd_rs_sel, fwd_rt_sel   : 0 = GRF, k+1 = result of scoreboard entry k
//   md_busy                  : multiply/divide unit still computing
module ctrl_hazard_scoreboard
    import ctrl_pkg::*;
#(
    parameter int STAGES      = 3,
    parameter int REG_W       = 5,
    parameter int TNEW_W      = CTRL_TNEW_W,
    parameter int MULT_CYCLES = CTRL_MULT_CYCLES,
    parameter int DIV_CYCLES  = CTRL_DIV_CYCLES,
    parameter int CNT_W       = 4,
    localparam int SEL_W      = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              d_valid,
    input  logic [REG_W-1:0]  d_rs,
    input  logic [REG_W-1:0]  d_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic              d_grfwe,
    input  logic [REG_W-1:0]  d_a3,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_is_div,
    input  logic              d_md_use,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic              md_busy
);

    logic [STAGES-1:0]             sb_v;
    logic [STAGES-1:0][REG_W-1:0]  sb_a3;
    logic [STAGES-1:0][TNEW_W-1:0] sb_tnew;

    // md_flag marks a start that is currently in E; md_div remembers its kind
    // so the counter can load the right latency when it leaves E.
    logic             md_flag;
    logic             md_div;
    logic [CNT_W-1:0] md_cnt;

    logic rs_stall;
    logic rt_stall;
    logic stall_md;
    logic issue;
    logic ins_v;

    hz_src_check #(
        .STAGES (STAGES),
        .REG_W  (REG_W),
        .TNEW_W (TNEW_W),
        .SEL_W  (SEL_W)
    ) u_rs_check (
        .sb_v      (sb_v),
        .sb_a3     (sb_a3),
        .sb_tnew   (sb_tnew),
        .src       (d_rs),
        .tuse      (d_tuse_rs),
        .src_stall (rs_stall),
        .fwd_sel   (fwd_rs_sel)
    );

    hz_src_check #(
        .STAGES (STAGES),
        .REG_W  (REG_W),
        .TNEW_W (TNEW_W),
        .SEL_W  (SEL_W)
    ) u_rt_check (
        .sb_v      (sb_v),
        .sb_a3     (sb_a3),
        .sb_tnew   (sb_tnew),
        .src       (d_rt),
        .tuse      (d_tuse_rt),
        .src_stall (rt_stall),
        .fwd_sel   (fwd_rt_sel)
    );

    assign md_busy  = (md_cnt != '0);
    // The start sitting in E has not loaded the counter yet, so the flag
    // covers that one cycle.
    assign stall_md = d_md_use & (md_busy | md_flag);
    assign stall    = d_valid & (rs_stall | rt_stall | stall_md);
    assign issue    = d_valid & ~stall;
    // Writes to $0 are discarded, so they never enter the scoreboard.
    assign ins_v    = issue & d_grfwe & (d_a3 != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_v    <= '0;
            sb_a3   <= '0;
            sb_tnew <= '0;
            md_flag <= 1'b0;
            md_div  <= 1'b0;
            md_cnt  <= '0;
        end else begin
            sb_v[0]    <= ins_v;
            sb_a3[0]   <= ins_v ? d_a3 : '0;
            sb_tnew[0] <= ins_v ? d_tnew : '0;
            for (int k = 1; k < STAGES; k++) begin
                sb_v[k]    <= sb_v[k-1];
                sb_a3[k]   <= sb_a3[k-1];
                sb_tnew[k] <= (sb_tnew[k-1] != '0) ? sb_tnew[k-1] - TNEW_W'(1) : '0;
            end

            md_flag <= issue & d_md_start;
            md_div  <= d_md_is_div;

            if (md_flag) begin
                md_cnt <= md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ctrl_hazard_scoreboard.sv
// Testbench for ctrl_hazard_scoreboard (default parameters).
// The reference model keeps, for each of the last STAGES cycles, the
// instruction that entered E that cycle with its original Tnew; remaining
// Tnew is derived from its age. HI/LO busy is derived from the cycle the
// last mult/div start left D.
module tb_ctrl_hazard_scoreboard;

    import ctrl_pkg::*;

    localparam int STAGES = 3;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam logic [1:0] UN = CTRL_TUSE_UNUSED;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_a3;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_grfwe, d_md_start, d_md_is_div, d_md_use;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    ctrl_hazard_scoreboard dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .d_valid     (d_valid),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rt   (d_tuse_rt),
        .d_grfwe     (d_grfwe),
        .d_a3        (d_a3),
        .d_tnew      (d_tnew),
        .d_md_start  (d_md_start),
        .d_md_is_div (d_md_is_div),
        .d_md_use    (d_md_use),
        .stall       (stall),
        .fwd_rs_sel  (fwd_rs_sel),
        .fwd_rt_sel  (fwd_rt_sel),
        .md_busy     (md_busy)
    );

    // ---------------- stimulus record ----------------
    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [1:0] tu_rs;
        logic [4:0] rt;
        logic [1:0] tu_rt;
        logic       we;
        logic [4:0] a3;
        logic [1:0] tn;
        logic       mds;
        logic       mdd;
        logic       mdu;
    } instr_t;

    function automatic instr_t mk(input logic v, input logic [4:0] rs, input logic [1:0] tu_rs,
                                  input logic [4:0] rt, input logic [1:0] tu_rt, input logic we,
                                  input logic [4:0] a3, input logic [1:0] tn, input logic mds,
                                  input logic mdd, input logic mdu);
        instr_t r;
        r.v = v; r.rs = rs; r.tu_rs = tu_rs; r.rt = rt; r.tu_rt = tu_rt;
        r.we = we; r.a3 = a3; r.tn = tn; r.mds = mds; r.mdd = mdd; r.mdu = mdu;
        return r;
    endfunction

    function automatic instr_t nop();
        return mk(1'b0, 5'd0, UN, 5'd0, UN, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];  // {stall, fwd_rs_sel, fwd_rt_sel, md_busy}

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic       v;
        logic [4:0] a3;
        int         tnew;
    } rec_t;

    rec_t hist[$];        // hist[k]: instruction that entered E k cycles ago
    int   cyc       = 0;
    int   md_issue  = -100;
    int   md_len    = 0;

    task automatic model_reset();
        rec_t b;
        b.v = 1'b0; b.a3 = '0; b.tnew = 0;
        hist.delete();
        for (int i = 0; i < STAGES; i++) hist.push_back(b);
        md_issue = -100;
        md_len   = 0;
    endtask

    function automatic void src_model(input logic [4:0] s, input logic [1:0] tu,
                                      output logic st, output logic [1:0] sel);
        st  = 1'b0;
        sel = 2'd0;
        if (s == 5'd0) return;
        for (int k = 0; k < hist.size(); k++) begin
            if (hist[k].v && hist[k].a3 == s) begin
                int left;
                left = hist[k].tnew - k;
                if (left < 0) left = 0;
                st  = (tu != UN) && (left > int'(tu));
                sel = (left == 0) ? 2'(k + 1) : 2'd0;
                return;
            end
        end
    endfunction

    function automatic logic [5:0] model_expect(input instr_t ins);
        logic st_rs, st_rt, md_flag_e, md_busy_e, st;
        logic [1:0] sel_rs, sel_rt;
        src_model(ins.rs, ins.tu_rs, st_rs, sel_rs);
        src_model(ins.rt, ins.tu_rt, st_rt, sel_rt);
        md_flag_e = (cyc == md_issue + 1);
        md_busy_e = (cyc >= md_issue + 2) && (cyc <= md_issue + 1 + md_len);
        st = ins.v && (st_rs || st_rt || (ins.mdu && (md_flag_e || md_busy_e)));
        return {st, sel_rs, sel_rt, md_busy_e};
    endfunction

    task automatic model_advance(input instr_t ins, input logic st);
        rec_t r;
        logic iss;
        iss    = ins.v && !st;
        r.v    = iss && ins.we && (ins.a3 != 5'd0);
        r.a3   = ins.a3;
        r.tnew = int'(ins.tn);
        hist.push_front(r);
        void'(hist.pop_back());
        if (iss && ins.mds) begin
            md_issue = cyc;
            md_len   = ins.mdd ? DIV_N : MULT_N;
        end
        cyc++;
    endtask

    // ---------------- driver ----------------
    task automatic apply(input instr_t ins);
        d_valid     = ins.v;
        d_rs        = ins.rs;
        d_tuse_rs   = ins.tu_rs;
        d_rt        = ins.rt;
        d_tuse_rt   = ins.tu_rt;
        d_grfwe     = ins.we;
        d_a3        = ins.a3;
        d_tnew      = ins.tn;
        d_md_start  = ins.mds;
        d_md_is_div = ins.mdd;
        d_md_use    = ins.mdu;
    endtask

    // Called shortly after a rising edge; returns just after the next one.
    task automatic step(input instr_t ins, output logic o_stall, output logic [1:0] o_rs,
                        output logic [1:0] o_rt, output logic o_busy);
        logic [5:0] e;
        apply(ins);
        e = model_expect(ins);
        exp_q.push_back(e);
        #1;
        o_stall = stall;
        o_rs    = fwd_rs_sel;
        o_rt    = fwd_rt_sel;
        o_busy  = md_busy;
        @(posedge clk);
        model_advance(ins, e[5]);
        #1;
    endtask

    task automatic step0(input instr_t ins);
        logic s, b;
        logic [1:0] r1, r2;
        step(ins, s, r1, r2, b);
    endtask

    task automatic flush();
        for (int i = 0; i < STAGES + 1; i++) step0(nop());
    endtask

    // Hold an instruction in D until it issues; report stall/busy cycle counts
    // and the selects seen on the issuing cycle.
    task automatic hold(input instr_t ins, output int n_stall, output int n_busy,
                        output logic [1:0] rs_sel, output logic [1:0] rt_sel);
        logic s, b;
        logic [1:0] r1, r2;
        n_stall = 0;
        n_busy  = 0;
        rs_sel  = 2'd0;
        rt_sel  = 2'd0;
        for (int i = 0; i < 40; i++) begin
            step(ins, s, r1, r2, b);
            if (b) n_busy++;
            if (!s) begin
                rs_sel = r1;
                rt_sel = r2;
                return;
            end
            n_stall++;
        end
        checks++;
        errors++;
        $display("FAIL hold_timeout: instruction still stalled after 40 cycles at %0t", $time);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [5:0] e;
            e = exp_q.pop_front();
            chk("mon_stall", int'(stall), int'(e[5]));
            chk("mon_md_busy", int'(md_busy), int'(e[0]));
            if (!e[5]) begin
                chk("mon_fwd_rs_sel", int'(fwd_rs_sel), int'(e[4:3]));
                chk("mon_fwd_rt_sel", int'(fwd_rt_sel), int'(e[2:1]));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int ns, nb;
        logic [1:0] s_rs, s_rt;
        instr_t ins;

        reset_n = 1'b0;
        apply(nop());
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state: a reader of $8 plus HI/LO use sees no hazard.
        apply(mk(1'b1, 5'd8, 2'd0, 5'd8, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1));
        #1;
        chk("reset_stall", int'(stall), 0);
        chk("reset_fwd_rs", int'(fwd_rs_sel), 0);
        chk("reset_fwd_rt", int'(fwd_rt_sel), 0);
        chk("reset_md_busy", int'(md_busy), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use: lw $8 (tnew 2), addu $9,$8,$8 (Tuse 1). On release $8's
        // producer sits in entry 1 with tnew 1, so D still selects the GRF.
        flush();
        step0(mk(1'b1, 5'd0, UN, 5'd0, UN, 1'b1, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0));
        hold(mk(1'b1, 5'd8, 2'd1, 5'd8, 2'd1, 1'b1, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0), ns, nb, s_rs, s_rt);
        chk("loaduse_stall_cycles", ns, 1);
        chk("loaduse_fwd_rs", int'(s_rs), 0);
        chk("loaduse_rs_eq_rt", int'(s_rt), int'(s_rs));

        // Branch after ALU: addu $4 (tnew 1), beq $4,$5 (Tuse 0).
        flush();
        step0(mk(1'b1, 5'd0, UN, 5'd0, UN, 1'b1, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0));
        hold(mk(1'b1, 5'd4, 2'd0, 5'd5, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0), ns, nb, s_rs, s_rt);
        chk("branch_stall_cycles", ns, 1);
        chk("branch_fwd_rs", int'(s_rs), 2);
        chk("branch_fwd_rt", int'(s_rt), 0);

        // Youngest wins: two writes to $3, both tnew 0, in entries 0 and 1.
        flush();
        step0(mk(1'b1, 5'd0, UN, 5'd0, UN, 1'b1, 5'd3, 2'd0, 1'b0, 1'b0, 1'b0));
        step0(mk(1'b1, 5'd0, UN, 5'd0, UN, 1'b1, 5'd3, 2'd0, 1'b0, 1'b0, 1'b0));
        hold(mk(1'b1, 5'd3, 2'd0, 5'd3, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0), ns, nb, s_rs, s_rt);
        chk("youngest_stall_cycles", ns, 0);
        chk("youngest_fwd_rs", int'(s_rs), 1);
        chk("youngest_fwd_rt", int'(s_rt), 1);

        // $0 destination never creates a hazard or a forward.
        flush();
        step0(mk(1'b1, 5'd0, UN, 5'd0, UN, 1'b1, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0));
        hold(mk(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0), ns, nb, s_rs, s_rt);
        chk("zero_stall_cycles", ns, 0);
        chk("zero_fwd_rs", int'(s_rs), 0);
        chk("zero_fwd_rt", int'(s_rt), 0);

        // div then mflo immediately.
        flush();
        step0(mk(1'b1, 5'd1, 2'd1, 5'd2, 2'd1, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1));
        hold(mk(1'b1, 5'd0, UN, 5'd0, UN, 1'b1, 5'd10, 2'd1, 1'b0, 1'b0, 1'b1), ns, nb, s_rs, s_rt);
        chk("div_stall_cycles", ns, DIV_N + 1);
        chk("div_busy_cycles", nb, DIV_N);

        // mult then mfhi immediately.
        flush();
        step0(mk(1'b1, 5'd1, 2'd1, 5'd2, 2'd1, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1));
        hold(mk(1'b1, 5'd0, UN, 5'd0, UN, 1'b1, 5'd11, 2'd1, 1'b0, 1'b0, 1'b1), ns, nb, s_rs, s_rt);
        chk("mult_stall_cycles", ns, MULT_N + 1);
        chk("mult_busy_cycles", nb, MULT_N);

        // Asynchronous reset while md is busy and entries are valid.
        flush();
        step0(mk(1'b1, 5'd1, 2'd1, 5'd2, 2'd1, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1));
        step0(mk(1'b1, 5'd0, UN, 5'd0, UN, 1'b1, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0));
        apply(mk(1'b1, 5'd7, 2'd0, 5'd0, UN, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1));
        #1;
        chk("prereset_stall", int'(stall), 1);
        chk("prereset_md_busy", int'(md_busy), 1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_stall", int'(stall), 0);
        chk("async_reset_md_busy", int'(md_busy), 0);
        chk("async_reset_fwd_rs", int'(fwd_rs_sel), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        hold(mk(1'b1, 5'd7, 2'd0, 5'd7, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1), ns, nb, s_rs, s_rt);
        chk("postreset_stall_cycles", ns, 0);

        // Randomized traffic over a small register set to force collisions.
        for (int i = 0; i < 800; i++) begin
            ins.v     = ($urandom_range(9) != 0);
            ins.rs    = 5'($urandom_range(7));
            ins.tu_rs = 2'($urandom_range(3));
            ins.rt    = 5'($urandom_range(7));
            ins.tu_rt = 2'($urandom_range(3));
            ins.we    = ($urandom_range(9) < 7);
            ins.a3    = 5'($urandom_range(7));
            ins.tn    = 2'($urandom_range(3));
            ins.mds   = ($urandom_range(24) == 0);
            ins.mdd   = 1'($urandom_range(1));
            ins.mdu   = ins.mds | ($urandom_range(7) == 0);
            step0(ins);
        end

        apply(nop());
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
